// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder on the CPU data bus.
// Provides a 32-bit output port, a synchronized 8-bit input port and a
// buffered 8N1 UART transmitter in a 16-byte register window:
//   0x0 PORTOUT (rw), 0x4 PORTIN (ro), 0x8 TXDATA (wo), 0xC STATUS.
//
// TX FSM states:
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high); chains straight into the next frame if queued
module mmio_io_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        UartTx,
    output logic        TxBusy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    logic [1:0]    offset;
    logic          wr_en;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          clr_ovf;

    logic [31:0]   port_out_q;
    logic [7:0]    sync1;
    logic [7:0]    sync2;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [4:0]    count_ext;
    logic          overflow;
    logic          full;
    logic          empty;

    tx_state_t     state, state_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          bit_end;
    logic          tx_q, tx_n;
    logic          busy_q, busy_n;
    logic [31:0]   status_word;

    // Only word-aligned accesses inside the window are claimed.
    assign Hit     = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
    assign offset  = Address[3:2];
    assign wr_en   = MemWrite && Hit;
    assign push    = wr_en && (offset == 2'd2);
    assign clr_ovf = wr_en && (offset == 2'd3) && WriteData[3];

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign push_ok = push && (!full || pop);
    assign count_ext = 5'(count);

    assign status_word = {23'b0, count_ext, overflow, empty, full, busy_q};
    assign PortOut = port_out_q;
    assign UartTx  = tx_q;
    assign TxBusy  = busy_q;
    assign bit_end = (bit_cnt == BIT_LAST);

    // Combinational load data; zero unless this is a load hitting the window.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead && Hit) begin
            case (offset)
                2'd0:    ReadData = port_out_q;
                2'd1:    ReadData = {24'b0, sync2};
                2'd2:    ReadData = 32'h0;
                default: ReadData = status_word;
            endcase
        end
    end

    // Output port register and two-flop input synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q <= 32'h0;
            sync1      <= 8'h0;
            sync2      <= 8'h0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            if (wr_en && (offset == 2'd0)) begin
                port_out_q <= WriteData;
            end
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // TX state register; line output and busy are registered to stay glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
        end
    end

    // TX next-state, FIFO pop and next line level.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        if (state != S_IDLE) begin
            bit_cnt_n = bit_end ? '0 : bit_cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_n   = fifo_mem[rd_ptr];
                    bit_cnt_n = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = 3'd0;
                        state_n   = S_STOP;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_mem[rd_ptr];
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
        endcase
        tx_n   = (state_n == S_DATA) ? shift_n[0] : (state_n != S_START);
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: register access, decode,
// input synchronizer, UART framing from a bit-stream model, FIFO overflow
// and asynchronous reset.
module tb_mmio_io_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        UartTx;
    logic        TxBusy;

    int n_assert = 0;
    int n_fail   = 0;

    mmio_io_responder #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .PortIn(PortIn),
        .ReadData(ReadData),
        .Hit(Hit),
        .PortOut(PortOut),
        .UartTx(UartTx),
        .TxBusy(TxBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        step();
        MemWrite  = 1'b0;
        Address   = 32'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data    = ReadData;
        MemRead = 1'b0;
        Address = 32'h0;
    endtask

    // Expected line waveform: frames back to back, each bit CPB cycles,
    // starting with the edge after the first push.
    task automatic check_stream(input logic [7:0] bytes[$]);
        logic bits[$];
        foreach (bytes[i]) begin
            bits.push_back(1'b0);
            for (int b = 0; b < 8; b++) bits.push_back(bytes[i][b]);
            bits.push_back(1'b1);
        end
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < CPB; c++) begin
                step();
                chk($sformatf("uart_bit%0d", k), {31'b0, UartTx}, {31'b0, bits[k]});
                chk("busy_in_frame", {31'b0, TxBusy}, 32'h1);
            end
        end
        step();
        chk("uart_idle_after", {31'b0, UartTx}, 32'h1);
        chk("busy_after", {31'b0, TxBusy}, 32'h0);
    endtask

    // Back-to-back TXDATA stores starting from idle; only the edge after the
    // first store pops, so 1+DEPTH bytes fit and the rest are dropped.
    task automatic tx_burst(input logic [7:0] q[$], output logic ovf_exp);
        logic [7:0] exp[$];
        for (int i = 0; i < q.size() && i < 1 + DEPTH; i++) exp.push_back(q[i]);
        ovf_exp = (q.size() > 1 + DEPTH);
        wr(BASE + 32'h8, {24'b0, q[0]});
        fork
            begin
                for (int i = 1; i < q.size(); i++) wr(BASE + 32'h8, {24'b0, q[i]});
            end
            check_stream(exp);
        join
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] model_port;
        logic [31:0] addr;
        logic [31:0] d;
        logic        exp_hit;
        logic        ovf;
        logic [7:0]  q[$];
        int          kind;
        int          n;

        reset = 1'b1; Address = 32'h0; WriteData = 32'h0;
        MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h0;
        step(); step();
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_uart", {31'b0, UartTx}, 32'h1);
        chk("rst_busy", {31'b0, TxBusy}, 32'h0);
        rd(BASE + 32'hC, r);
        chk("rst_status", r, 32'h4);
        reset = 1'b0;
        step();

        // PORTOUT access and decode
        wr(BASE, 32'hDEADBEEF);
        rd(BASE, r);
        chk("portout_read", r, 32'hDEADBEEF);
        chk("portout_pin", PortOut, 32'hDEADBEEF);
        rd(BASE + 32'h8, r);
        chk("txdata_read", r, 32'h0);
        Address = BASE + 32'h1; #1;
        chk("hit_misaligned", {31'b0, Hit}, 32'h0);
        wr(BASE + 32'h1, 32'h12345678);
        chk("portout_misaligned", PortOut, 32'hDEADBEEF);
        wr(BASE + 32'h10, 32'h12345678);
        chk("portout_outside", PortOut, 32'hDEADBEEF);
        rd(BASE + 32'h10, r);
        chk("read_outside", r, 32'h0);
        Address = BASE; MemRead = 1'b0; #1;
        chk("read_no_strobe", ReadData, 32'h0);
        Address = 32'h0;

        // Random PORTOUT traffic with decode model
        model_port = 32'hDEADBEEF;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 3);
            d = $urandom;
            case (kind)
                0: addr = BASE;
                1: addr = BASE + 32'($urandom_range(1, 3));
                2: addr = BASE + 32'h10 + (32'($urandom_range(0, 15)) << 4);
                default: addr = BASE;
            endcase
            exp_hit = (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
            Address = addr; WriteData = d; MemWrite = 1'b1;
            MemRead = (kind == 3); #1;
            chk("rand_hit", {31'b0, Hit}, {31'b0, exp_hit});
            if (kind == 3) chk("rand_pre_edge_read", ReadData, model_port);
            step();
            MemWrite = 1'b0; MemRead = 1'b0; Address = 32'h0;
            if (exp_hit) model_port = d;
            chk("rand_portout", PortOut, model_port);
        end

        // PortIn synchronizer
        PortIn = 8'hA5;
        step();
        rd(BASE + 32'h4, r);
        chk("portin_1edge", r, 32'h0);
        step();
        rd(BASE + 32'h4, r);
        chk("portin_2edge", r, 32'hA5);
        d = $urandom;
        PortIn = d[7:0];
        step(); step();
        rd(BASE + 32'h4, r);
        chk("portin_rand", r, {24'b0, d[7:0]});

        // Single 0x55 frame with latency checks
        Address = BASE + 32'h8; WriteData = 32'h55; MemWrite = 1'b1;
        step();
        MemWrite = 1'b0; Address = 32'h0;
        chk("edgeN_uart", {31'b0, UartTx}, 32'h1);
        chk("edgeN_busy", {31'b0, TxBusy}, 32'h0);
        q = '{8'h55};
        check_stream(q);
        rd(BASE + 32'hC, r);
        chk("status_after_frame", r, 32'h4);

        // Random burst that fits
        q.delete();
        n = $urandom_range(1, 1 + DEPTH);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        tx_burst(q, ovf);
        rd(BASE + 32'hC, r);
        chk("status_rand_burst", r, {28'b0, ovf, 3'b100});

        // Overflow burst 01..06
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        tx_burst(q, ovf);
        rd(BASE + 32'hC, r);
        chk("status_overflow", r, {28'b0, ovf, 3'b100});
        wr(BASE + 32'hC, 32'h8);
        rd(BASE + 32'hC, r);
        chk("status_ovf_clear", r, 32'h4);

        // Reset during DATA bit 3 with a second byte queued
        wr(BASE, 32'hCAFEF00D);
        wr(BASE + 32'h8, 32'hC3);
        wr(BASE + 32'h8, 32'h3C);
        for (int i = 0; i < 68; i++) step();
        chk("pre_reset_busy", {31'b0, TxBusy}, 32'h1);
        chk("pre_reset_bit3", {31'b0, UartTx}, 32'h0);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_uart", {31'b0, UartTx}, 32'h1);
        chk("async_rst_busy", {31'b0, TxBusy}, 32'h0);
        chk("async_rst_portout", PortOut, 32'h0);
        step(); step();
        reset = 1'b0;
        rd(BASE + 32'hC, r);
        chk("post_rst_status", r, 32'h4);
        rd(BASE, r);
        chk("post_rst_portout", r, 32'h0);
        for (int i = 0; i < 200; i++) begin
            step();
            chk("no_frame_after_rst", {30'b0, TxBusy, UartTx}, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
